// File: rtl/regression_lms_trainer_pkg.sv
// Shared types, widths and saturating helpers for the LMS trainer.
package regression_lms_trainer_pkg;

  localparam int COEF0_W = 32;
  localparam int COEF_W  = 16;
  localparam int FEAT_W  = 16;
  localparam int ERR_W   = 33;
  localparam int PROD_W  = 50;

  typedef enum logic [3:0] {
    IDLE, MAC0, MAC1, MAC2, ERR, UPD0, UPD1, UPD2, RESP
  } state_t;

  // Unsigned 16-bit coefficient plus signed delta, clamped to [0, 65535].
  function automatic logic [COEF_W-1:0] sat16u(input logic [COEF_W-1:0] c,
                                                input logic signed [PROD_W-1:0] d);
    logic signed [PROD_W:0] s;
    s = $signed({35'd0, c}) + $signed({d[PROD_W-1], d});
    if (s[PROD_W])         return '0;
    else if (|s[PROD_W-1:COEF_W]) return '1;
    else                   return s[COEF_W-1:0];
  endfunction

  // Unsigned 32-bit coefficient plus signed delta, clamped to [0, 2^32-1].
  function automatic logic [COEF0_W-1:0] sat32u(input logic [COEF0_W-1:0] c,
                                                 input logic signed [ERR_W-1:0] d);
    logic signed [COEF0_W+1:0] s;
    s = $signed({2'b00, c}) + $signed({d[ERR_W-1], d});
    if (s[COEF0_W+1])    return '0;
    else if (s[COEF0_W]) return '1;
    else                 return s[COEF0_W-1:0];
  endfunction

endpackage

// File: rtl/regression_lms_trainer_if.sv
// Sample, coefficient and result signals of the LMS trainer.
interface regression_lms_trainer_if;
  logic        coef_load;
  logic [31:0] c0_init;
  logic [15:0] c1_init, c2_init, c3_init;
  logic        train_en;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] f0, f1, f2;
  logic [31:0] target;
  logic [31:0] c0;
  logic [15:0] c1, c2, c3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y_pred;
  logic [32:0] err;

  modport slave (
    input  coef_load, c0_init, c1_init, c2_init, c3_init, train_en,
           in_valid, f0, f1, f2, target, out_ready,
    output in_ready, c0, c1, c2, c3, out_valid, y_pred, err
  );

  modport master (
    output coef_load, c0_init, c1_init, c2_init, c3_init, train_en,
           in_valid, f0, f1, f2, target, out_ready,
    input  in_ready, c0, c1, c2, c3, out_valid, y_pred, err
  );
endinterface

// File: rtl/regression_lms_trainer_lms_mac_unit.sv
// Shared signed multiplier and wrapping accumulator; operands chosen by FSM phase.
module lms_mac_unit
  import regression_lms_trainer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  state_t                   state,
  input  logic                     acc_load,
  input  logic [COEF0_W-1:0]       acc_init,
  input  logic [COEF_W-1:0]        c1, c2, c3,
  input  logic [FEAT_W-1:0]        f0, f1, f2,
  input  logic signed [ERR_W-1:0]  err,
  output logic signed [PROD_W-1:0] product,
  output logic [COEF0_W-1:0]       acc
);

  logic [COEF_W-1:0]        coef;
  logic [FEAT_W-1:0]        feat;
  logic signed [ERR_W-1:0]  op_a;
  logic signed [FEAT_W:0]   op_b;
  logic [COEF0_W-1:0]       acc_q, acc_d;

  // Select the coefficient/feature pair for the current phase; in UPD phases
  // the coefficient operand is replaced by the latched error.
  always_comb begin
    coef = '0;
    feat = '0;
    case (state)
      MAC0, UPD0: begin coef = c1; feat = f0; end
      MAC1, UPD1: begin coef = c2; feat = f1; end
      MAC2, UPD2: begin coef = c3; feat = f2; end
      default: ;
    endcase
    op_a    = (state inside {UPD0, UPD1, UPD2}) ? err : $signed({17'd0, coef});
    op_b    = $signed({1'b0, feat});
    product = $signed({{17{op_a[ERR_W-1]}}, op_a}) * $signed({33'd0, op_b});
  end

  // Accumulator: seeded with c0 on accept, adds one product per MAC phase.
  always_comb begin
    acc_d = acc_q;
    if (acc_load)
      acc_d = acc_init;
    else if (state inside {MAC0, MAC1, MAC2})
      acc_d = acc_q + product[COEF0_W-1:0];
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/regression_lms_trainer.sv
// Serial LMS trainer: predicts y with current coefficients, then optionally
// nudges c0..c3 toward the target using one shared multiplier.
module regression_lms_trainer
  import regression_lms_trainer_pkg::*;
#(
  parameter int MU_SHIFT  = 8,
  parameter int MU_SHIFT0 = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regression_lms_trainer_if.slave bus
);

  state_t                  state_q, state_d;
  logic [COEF0_W-1:0]      c0_q, c0_d;
  logic [COEF_W-1:0]       c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic [FEAT_W-1:0]       f0_q, f0_d, f1_q, f1_d, f2_q, f2_d;
  logic [COEF0_W-1:0]      target_q, target_d;
  logic                    train_q, train_d;
  logic [COEF0_W-1:0]      y_pred_q, y_pred_d;
  logic signed [ERR_W-1:0] err_q, err_d;

  logic                     in_ready;
  logic                     acc_load;
  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] delta;
  logic [COEF0_W-1:0]       acc;

  assign in_ready = (state_q == IDLE) && !bus.coef_load;
  assign delta    = product >>> MU_SHIFT;

  lms_mac_unit u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (state_q),
    .acc_load (acc_load),
    .acc_init (c0_q),
    .c1       (c1_q),
    .c2       (c2_q),
    .c3       (c3_q),
    .f0       (f0_q),
    .f1       (f1_q),
    .f2       (f2_q),
    .err      (err_q),
    .product  (product),
    .acc      (acc)
  );

  // Next-state, sample capture and coefficient update logic.
  always_comb begin
    state_d  = state_q;
    c0_d     = c0_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    c3_d     = c3_q;
    f0_d     = f0_q;
    f1_d     = f1_q;
    f2_d     = f2_q;
    target_d = target_q;
    train_d  = train_q;
    y_pred_d = y_pred_q;
    err_d    = err_q;
    acc_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.coef_load) begin
          c0_d = bus.c0_init;
          c1_d = bus.c1_init;
          c2_d = bus.c2_init;
          c3_d = bus.c3_init;
        end else if (bus.in_valid) begin
          f0_d     = bus.f0;
          f1_d     = bus.f1;
          f2_d     = bus.f2;
          target_d = bus.target;
          train_d  = bus.train_en;
          acc_load = 1'b1;
          state_d  = MAC0;
        end
      end
      MAC0: state_d = MAC1;
      MAC1: state_d = MAC2;
      MAC2: state_d = ERR;
      ERR: begin
        y_pred_d = acc;
        err_d    = $signed({1'b0, target_q}) - $signed({1'b0, acc});
        state_d  = train_q ? UPD0 : RESP;
      end
      UPD0: begin
        c1_d    = sat16u(c1_q, delta);
        c0_d    = sat32u(c0_q, err_q >>> MU_SHIFT0);
        state_d = UPD1;
      end
      UPD1: begin
        c2_d    = sat16u(c2_q, delta);
        state_d = UPD2;
      end
      UPD2: begin
        c3_d    = sat16u(c3_q, delta);
        state_d = RESP;
      end
      RESP: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any sample in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      c0_q     <= '0;
      c1_q     <= '0;
      c2_q     <= '0;
      c3_q     <= '0;
      f0_q     <= '0;
      f1_q     <= '0;
      f2_q     <= '0;
      target_q <= '0;
      train_q  <= 1'b0;
      y_pred_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      c0_q     <= c0_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      c3_q     <= c3_d;
      f0_q     <= f0_d;
      f1_q     <= f1_d;
      f2_q     <= f2_d;
      target_q <= target_d;
      train_q  <= train_d;
      y_pred_q <= y_pred_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == RESP);
  assign bus.c0        = c0_q;
  assign bus.c1        = c1_q;
  assign bus.c2        = c2_q;
  assign bus.c3        = c3_q;
  assign bus.y_pred    = y_pred_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_regression_lms_trainer.sv
// Self-checking bench for regression_lms_trainer against an arithmetic model.
module tb_regression_lms_trainer;

  localparam int MU   = 8;
  localparam int MU0  = 4;
  localparam int LATB = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Model coefficients and expected result of the most recent sample.
  longint m_c0, m_c1, m_c2, m_c3;
  longint exp_y, exp_err;

  regression_lms_trainer_if bus ();

  regression_lms_trainer #(.MU_SHIFT(MU), .MU_SHIFT0(MU0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint clamp(input longint v, input longint hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Model: prediction from the regression formula, then LMS step if training.
  task automatic model_sample(input longint a, input longint b, input longint c,
                              input longint t, input bit tr);
    longint e;
    exp_y   = (m_c0 + m_c1 * a + m_c2 * b + m_c3 * c) % 64'h1_0000_0000;
    exp_err = t - exp_y;
    e = exp_err;
    if (tr) begin
      m_c0 = clamp(m_c0 + (e >>> MU0), 64'hFFFF_FFFF);
      m_c1 = clamp(m_c1 + ((e * a) >>> MU), 65535);
      m_c2 = clamp(m_c2 + ((e * b) >>> MU), 65535);
      m_c3 = clamp(m_c3 + ((e * c) >>> MU), 65535);
    end
  endtask

  task automatic load_coefs(input longint a, input longint b, input longint c, input longint d);
    bus.c0_init = a[31:0];
    bus.c1_init = b[15:0];
    bus.c2_init = c[15:0];
    bus.c3_init = d[15:0];
    bus.coef_load = 1'b1;
    @(posedge clk); #1;
    bus.coef_load = 1'b0;
    m_c0 = a; m_c1 = b; m_c2 = c; m_c3 = d;
  endtask

  // Present a sample and return once the accept edge has passed (bounded).
  task automatic start_sample(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                              input logic [31:0] t, input bit tr);
    bit ok;
    ok = 1'b0;
    bus.f0 = a; bus.f1 = b; bus.f2 = c; bus.target = t; bus.train_en = tr;
    bus.in_valid = 1'b1;
    for (int i = 0; i < LATB && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < LATB) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.c0, bus.c1, bus.c2, bus.c3, bus.y_pred, bus.err, bus.out_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got c0=%0d y=%0d err=%0d ov=%0b, want all 0",
               bus.c0, bus.y_pred, bus.err, bus.out_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_predict();
    int lat;
    load_coefs(50000, 200, 700, 65);
    model_sample(1000, 30000, 600, 21289000, 1'b0);
    start_sample(16'd1000, 16'd30000, 16'd600, 32'd21289000, 1'b0);
    wait_out(lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL predict_latency: got %0d want 4", lat); end
    checks++;
    if (bus.y_pred !== 32'd21289000) begin
      errors++; $display("FAIL predict_y: got %0d want 21289000", bus.y_pred);
    end
    checks++;
    if (longint'($signed(bus.err)) != 0) begin
      errors++; $display("FAIL predict_err: got %0d want 0", $signed(bus.err));
    end
    checks++;
    if ({bus.c0, bus.c1, bus.c2, bus.c3} !== {32'd50000, 16'd200, 16'd700, 16'd65}) begin
      errors++; $display("FAIL predict_coefs: got %0d %0d %0d %0d want 50000 200 700 65",
                         bus.c0, bus.c1, bus.c2, bus.c3);
    end
    handshake();
  endtask

  task automatic test_train_step();
    int lat;
    load_coefs(0, 0, 0, 0);
    start_sample(16'd256, 16'd0, 16'd0, 32'd1000, 1'b1);
    wait_out(lat);
    checks++;
    if (lat != 7) begin errors++; $display("FAIL train_latency: got %0d want 7", lat); end
    checks++;
    if (bus.y_pred !== 32'd0 || $signed(bus.err) !== 33'sd1000) begin
      errors++; $display("FAIL train_result: got y=%0d err=%0d want y=0 err=1000",
                         bus.y_pred, $signed(bus.err));
    end
    checks++;
    if ({bus.c0, bus.c1, bus.c2, bus.c3} !== {32'd62, 16'd1000, 16'd0, 16'd0}) begin
      errors++; $display("FAIL train_coefs: got %0d %0d %0d %0d want 62 1000 0 0",
                         bus.c0, bus.c1, bus.c2, bus.c3);
    end
    handshake();
  endtask

  task automatic test_sat_low();
    int lat;
    load_coefs(0, 10, 0, 0);
    start_sample(16'd256, 16'd0, 16'd0, 32'd0, 1'b1);
    wait_out(lat);
    checks++;
    if (bus.y_pred !== 32'd2560 || $signed(bus.err) !== -33'sd2560) begin
      errors++; $display("FAIL satlow_result: got y=%0d err=%0d want y=2560 err=-2560",
                         bus.y_pred, $signed(bus.err));
    end
    checks++;
    if ({bus.c0, bus.c1, bus.c2, bus.c3} !== '0) begin
      errors++; $display("FAIL satlow_coefs: got %0d %0d %0d %0d want 0 0 0 0",
                         bus.c0, bus.c1, bus.c2, bus.c3);
    end
    handshake();
  endtask

  task automatic test_wrap();
    int lat;
    load_coefs(64'hFFFF_FFFF, 1, 0, 0);
    start_sample(16'd1, 16'd0, 16'd0, 32'd0, 1'b1);
    wait_out(lat);
    checks++;
    if (bus.y_pred !== 32'd0 || $signed(bus.err) !== 33'sd0) begin
      errors++; $display("FAIL wrap_result: got y=%0d err=%0d want 0 0", bus.y_pred, $signed(bus.err));
    end
    checks++;
    if ({bus.c0, bus.c1, bus.c2, bus.c3} !== {32'hFFFF_FFFF, 16'd1, 16'd0, 16'd0}) begin
      errors++; $display("FAIL wrap_coefs: got %0d %0d %0d %0d want 4294967295 1 0 0",
                         bus.c0, bus.c1, bus.c2, bus.c3);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    load_coefs(123, 4, 5, 6);
    model_sample(77, 88, 99, 40000, 1'b1);
    start_sample(16'd77, 16'd88, 16'd99, 32'd40000, 1'b1);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          longint'(bus.y_pred) != exp_y || longint'($signed(bus.err)) != exp_err ||
          {bus.c0, bus.c1, bus.c2, bus.c3} !== {m_c0[31:0], m_c1[15:0], m_c2[15:0], m_c3[15:0]}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got ov=%b ir=%b y=%0d err=%0d c=%0d/%0d/%0d/%0d want ov=1 ir=0 y=%0d err=%0d c=%0d/%0d/%0d/%0d",
                 i, bus.out_valid, bus.in_ready, bus.y_pred, $signed(bus.err),
                 bus.c0, bus.c1, bus.c2, bus.c3, exp_y, exp_err, m_c0, m_c1, m_c2, m_c3);
      end
      @(posedge clk); #1;
    end
    handshake();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release: got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_load_priority();
    int lat;
    bus.f0 = 16'd3; bus.f1 = 16'd4; bus.f2 = 16'd5; bus.target = 32'd0; bus.train_en = 1'b0;
    bus.c0_init = 32'd10; bus.c1_init = 16'd1; bus.c2_init = 16'd2; bus.c3_init = 16'd3;
    bus.coef_load = 1'b1;
    bus.in_valid  = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL prio_in_ready: got %b want 0", bus.in_ready); end
    @(posedge clk); #1;
    bus.coef_load = 1'b0;
    m_c0 = 10; m_c1 = 1; m_c2 = 2; m_c3 = 3;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || {bus.c0, bus.c1, bus.c2, bus.c3} !== {32'd10, 16'd1, 16'd2, 16'd3}) begin
      errors++; $display("FAIL prio_load: got ir=%b c=%0d/%0d/%0d/%0d want ir=1 c=10/1/2/3",
                         bus.in_ready, bus.c0, bus.c1, bus.c2, bus.c3);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    model_sample(3, 4, 5, 0, 1'b0);
    wait_out(lat);
    checks++;
    if (lat != 4 || longint'(bus.y_pred) != exp_y) begin
      errors++; $display("FAIL prio_sample: got lat=%0d y=%0d want lat=4 y=%0d", lat, bus.y_pred, exp_y);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat;
    load_coefs(50000, 200, 700, 65);
    start_sample(16'd1000, 16'd30000, 16'd600, 32'd21289000, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.c0, bus.c1, bus.c2, bus.c3, bus.y_pred, bus.err, bus.out_valid} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got c0=%0d c1=%0d y=%0d ov=%b want all 0",
                         bus.c0, bus.c1, bus.y_pred, bus.out_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    m_c0 = 0; m_c1 = 0; m_c2 = 0; m_c3 = 0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", bus.in_ready); end
    start_sample(16'd1000, 16'd30000, 16'd600, 32'd21289000, 1'b0);
    wait_out(lat);
    checks++;
    if (bus.y_pred !== 32'd0 || $signed(bus.err) !== 33'sd21289000) begin
      errors++; $display("FAIL midreset_predict: got y=%0d err=%0d want y=0 err=21289000",
                         bus.y_pred, $signed(bus.err));
    end
    handshake();
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] a, b, c;
    logic [31:0] t;
    bit tr;
    for (int n = 0; n < 25; n++) begin
      if (n % 6 == 0)
        load_coefs($urandom, $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535));
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
      t  = (n % 2 == 0) ? $urandom : 32'($urandom_range(0, 300000));
      tr = 1'($urandom_range(0, 1));
      model_sample(a, b, c, t, tr);
      start_sample(a, b, c, t, tr);
      wait_out(lat);
      checks++;
      if (lat != (tr ? 7 : 4) || longint'(bus.y_pred) != exp_y || longint'($signed(bus.err)) != exp_err ||
          {bus.c0, bus.c1, bus.c2, bus.c3} !== {m_c0[31:0], m_c1[15:0], m_c2[15:0], m_c3[15:0]}) begin
        errors++;
        $display("FAIL random%0d: got lat=%0d y=%0d err=%0d c=%0d/%0d/%0d/%0d want lat=%0d y=%0d err=%0d c=%0d/%0d/%0d/%0d",
                 n, lat, bus.y_pred, $signed(bus.err), bus.c0, bus.c1, bus.c2, bus.c3,
                 tr ? 7 : 4, exp_y, exp_err, m_c0, m_c1, m_c2, m_c3);
      end
      handshake();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_c0 = 0; m_c1 = 0; m_c2 = 0; m_c3 = 0;
    rst_n = 1'b0;
    bus.coef_load = 1'b0;
    bus.c0_init = '0; bus.c1_init = '0; bus.c2_init = '0; bus.c3_init = '0;
    bus.train_en = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.f0 = '0; bus.f1 = '0; bus.f2 = '0; bus.target = '0;
    #23;
    test_reset();
    test_predict();
    test_train_step();
    test_sat_low();
    test_wrap();
    test_backpressure();
    test_load_priority();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
